// File: rtl/mmio_fabric_pkg.sv
// Shared types and defaults for the MMIO fabric: FSM state encoding, parameter
// defaults and a constant-foldable clog2 used to size the slave-select field.
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int DEF_NUM_SLV     = 4;
  localparam int DEF_DW          = 32;
  localparam int DEF_SEL_LSB     = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_fabric_addr_dec.sv
// Combinational slave-select decoder: extracts the select field from an address
// and flags whether it names an existing slave channel.
module mmio_addr_dec
  import mmio_fabric_pkg::*;
#(
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int SEL_LSB = DEF_SEL_LSB,
  parameter int IW      = clog2(DEF_NUM_SLV) + 1
) (
  input  logic [31:0]   addr_i,
  output logic [IW-1:0] idx_o,
  output logic          in_range_o
);

  // The field is one bit wider than needed so indices past NUM_SLV are visible.
  localparam logic [IW-1:0] NUM_SLV_W = IW'(NUM_SLV);

  logic unused_addr_bits;

  assign idx_o            = addr_i[SEL_LSB +: IW];
  assign in_range_o       = (idx_o < NUM_SLV_W);
  assign unused_addr_bits = ^addr_i;

endmodule

// File: rtl/mmio_fabric.sv
// Single-master MMIO fabric: one outstanding request routed to NUM_SLV slave
// channels. Optional wait-state timeout enabled by macro MMIO_FABRIC_TIMEOUT_EN.
//
// Handshake: a request transfers on a clk edge where req_valid && req_ready;
// req_ready is high only while idle. A response is a single-cycle rsp_valid
// pulse with rsp_err/rsp_rdata valid in that cycle. A slave completes the
// access by raising its slv_ready bit while its slv_sel bit is high.
module mmio_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int NUM_SLV     = DEF_NUM_SLV,
  parameter int DW          = DEF_DW,
  parameter int SEL_LSB     = DEF_SEL_LSB,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DW-1:0]         req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DW-1:0]         rsp_rdata,
  output logic [NUM_SLV-1:0]    slv_sel,
  output logic                  slv_we,
  output logic [31:0]           slv_addr,
  output logic [DW-1:0]         slv_wdata,
  input  logic [NUM_SLV*DW-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]    slv_ready,
  output logic [7:0]            err_cnt,
  output logic [1:0]            dbg_state
);

  localparam int IW = clog2(NUM_SLV) + 1;

  state_e               state_q;
  logic [31:0]          addr_q;
  logic                 we_q;
  logic [DW-1:0]        wdata_q;
  logic [NUM_SLV-1:0]   sel_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [DW-1:0]        rsp_rdata_q;
  logic [7:0]           err_cnt_q;

  logic [IW-1:0]        dec_idx;
  logic                 dec_hit;
  logic [NUM_SLV-1:0]   dec_onehot;
  logic                 sel_ready;
  logic [DW-1:0]        sel_rdata;
  logic [7:0]           err_cnt_inc;

`ifdef MMIO_FABRIC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0]           wait_q;
`endif

  mmio_addr_dec #(
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB),
    .IW      (IW)
  ) u_dec (
    .addr_i     (req_addr),
    .idx_o      (dec_idx),
    .in_range_o (dec_hit)
  );

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      dec_onehot[i] = (dec_idx == IW'(i));
    end
  end

  // Route through the registered one-hot select so unselected channels never
  // contribute to ready or read data.
  always_comb begin
    sel_ready = |(slv_ready & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
    end
  end

  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (dec_hit) begin
              state_q <= ST_ACCESS;
              sel_q   <= dec_onehot;
`ifdef MMIO_FABRIC_TIMEOUT_EN
              wait_q  <= '0;
`endif
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              err_cnt_q   <= err_cnt_inc;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is tested first so a slave answering on the timeout cycle wins.
          if (sel_ready) begin
            state_q     <= ST_RESP;
            sel_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= sel_rdata;
          end
`ifdef MMIO_FABRIC_TIMEOUT_EN
          else if (wait_q == TO_LAST) begin
            state_q     <= ST_RESP;
            sel_q       <= '0;
            wait_q      <= wait_q + 8'd1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            err_cnt_q   <= err_cnt_inc;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          sel_q       <= '0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign slv_sel   = sel_q;
  assign slv_we    = we_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule
